// File: rtl/ble_encoder_arbiter.sv
// Round-robin arbiter sharing one bluetooth_encoder between NUM_REQ requesters.
// Latches the winner's payload, runs start/done with a watchdog, returns the 144-bit packet.
module ble_encoder_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [32*NUM_REQ-1:0] i_req_data,
  input  logic [4*NUM_REQ-1:0]  i_req_cmd,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [NUM_REQ-1:0]    o_resp_valid,
  output logic [143:0]          o_resp_data,
  output logic                  o_resp_error,
  output logic                  o_busy,
  output logic [31:0]           o_enc_input_data,
  output logic [3:0]            o_enc_cmd,
  output logic                  o_enc_start,
  input  logic [143:0]          i_enc_output,
  input  logic                  i_enc_done
);

  localparam int              IW         = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [7:0]      TMO        = 8'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]   LAST_RST   = IW'(NUM_REQ - 1);
  localparam logic [2:0]      ST_IDLE    = 3'd0;
  localparam logic [2:0]      ST_LAUNCH  = 3'd1;
  localparam logic [2:0]      ST_WAIT    = 3'd2;
  localparam logic [2:0]      ST_RESPOND = 3'd3;

  logic [2:0]         r_state,      w_state_nxt;
  logic [7:0]         r_cnt,        w_cnt_nxt;
  logic [IW-1:0]      r_last,       w_last_nxt;
  logic [IW-1:0]      r_owner,      w_owner_nxt;
  logic [NUM_REQ-1:0] r_grant,      w_grant_nxt;
  logic [NUM_REQ-1:0] r_resp_valid, w_resp_valid_nxt;
  logic [143:0]       r_resp_data,  w_resp_data_nxt;
  logic               r_resp_error, w_resp_error_nxt;
  logic               r_busy,       w_busy_nxt;
  logic [31:0]        r_enc_data,   w_enc_data_nxt;
  logic [3:0]         r_enc_cmd,    w_enc_cmd_nxt;
  logic               r_enc_start,  w_enc_start_nxt;

  int                 w_scan;
  logic               w_found;
  logic [IW-1:0]      w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_done_hit;
  logic               w_timeout;

  // Scan starts just after the previous owner, wrapping, so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_scan   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_scan = int'(r_last) + i;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      if (!w_found && i_req[w_scan[IW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scan[IW-1:0];
      end
    end
  end

  assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
  // The encoder idles with done high, so a done seen on the first WAIT cycle is stale.
  assign w_done_hit = i_enc_done && (r_cnt != 8'd0);
  assign w_timeout  = (r_cnt == TMO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_last       <= LAST_RST;
      r_owner      <= '0;
      r_grant      <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
      r_busy       <= 1'b0;
      r_enc_data   <= '0;
      r_enc_cmd    <= '0;
      r_enc_start  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last       <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_grant      <= w_grant_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_resp_error <= w_resp_error_nxt;
      r_busy       <= w_busy_nxt;
      r_enc_data   <= w_enc_data_nxt;
      r_enc_cmd    <= w_enc_cmd_nxt;
      r_enc_start  <= w_enc_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_found) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH:  w_state_nxt = ST_WAIT;
      ST_WAIT:    if (w_done_hit || w_timeout) w_state_nxt = ST_RESPOND;
      ST_RESPOND: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_last_nxt       = r_last;
    w_owner_nxt      = r_owner;
    w_grant_nxt      = r_grant;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_data_nxt  = r_resp_data;
    w_resp_error_nxt = r_resp_error;
    w_busy_nxt       = r_busy;
    w_enc_data_nxt   = r_enc_data;
    w_enc_cmd_nxt    = r_enc_cmd;
    w_enc_start_nxt  = r_enc_start;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_owner_nxt     = w_winner;
          w_grant_nxt     = w_onehot;
          w_enc_data_nxt  = i_req_data[32*int'(w_winner) +: 32];
          w_enc_cmd_nxt   = i_req_cmd[4*int'(w_winner) +: 4];
          w_enc_start_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end
      ST_LAUNCH: begin
        w_enc_start_nxt = 1'b0;
        w_cnt_nxt       = 8'd0;
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if (w_done_hit) begin
          w_resp_data_nxt  = i_enc_output;
          w_resp_error_nxt = 1'b0;
          w_resp_valid_nxt = r_grant;
        end else if (w_timeout) begin
          w_resp_data_nxt  = '0;
          w_resp_error_nxt = 1'b1;
          w_resp_valid_nxt = r_grant;
        end
      end
      ST_RESPOND: begin
        w_resp_valid_nxt = '0;
        w_grant_nxt      = '0;
        w_busy_nxt       = 1'b0;
        w_last_nxt       = r_owner;
      end
      default: begin
        w_cnt_nxt        = 8'd0;
        w_grant_nxt      = '0;
        w_resp_valid_nxt = '0;
        w_resp_data_nxt  = '0;
        w_resp_error_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_enc_data_nxt   = '0;
        w_enc_cmd_nxt    = '0;
        w_enc_start_nxt  = 1'b0;
      end
    endcase
  end

  assign o_grant          = r_grant;
  assign o_resp_valid     = r_resp_valid;
  assign o_resp_data      = r_resp_data;
  assign o_resp_error     = r_resp_error;
  assign o_busy           = r_busy;
  assign o_enc_input_data = r_enc_data;
  assign o_enc_cmd        = r_enc_cmd;
  assign o_enc_start      = r_enc_start;

endmodule

// File: tb/tb_ble_encoder_arbiter.sv
// Bench for ble_encoder_arbiter: directed scenarios plus randomized transactions
// against a round-robin / latency reference model.
module tb_ble_encoder_arbiter;

  localparam int NR  = 2;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   i_req;
  logic [32*NR-1:0] i_req_data;
  logic [4*NR-1:0] i_req_cmd;
  logic [NR-1:0]   o_grant;
  logic [NR-1:0]   o_resp_valid;
  logic [143:0]    o_resp_data;
  logic            o_resp_error;
  logic            o_busy;
  logic [31:0]     o_enc_input_data;
  logic [3:0]      o_enc_cmd;
  logic            o_enc_start;
  logic [143:0]    i_enc_output;
  logic            i_enc_done;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [NR-1:0] cur_req;
  int            m_last;

  ble_encoder_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_req            (i_req),
    .i_req_data       (i_req_data),
    .i_req_cmd        (i_req_cmd),
    .o_grant          (o_grant),
    .o_resp_valid     (o_resp_valid),
    .o_resp_data      (o_resp_data),
    .o_resp_error     (o_resp_error),
    .o_busy           (o_busy),
    .o_enc_input_data (o_enc_input_data),
    .o_enc_cmd        (o_enc_cmd),
    .o_enc_start      (o_enc_start),
    .i_enc_output     (i_enc_output),
    .i_enc_done       (i_enc_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int i = 1; i <= NR; i++)
      if (r[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  function automatic logic [143:0] rnd144();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[143:0];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after RESPOND.
  task automatic run_txn(input logic [NR-1:0] set_bits, input logic [32*NR-1:0] d,
                         input logic [4*NR-1:0] cm, input logic [143:0] eo, input int k,
                         input bit stuck, input bit glitch, input bit late, input bit drop,
                         input bit hold);
    int            w;
    int            exp_r;
    int            r_obs;
    int            starts;
    bit            exp_err;
    bit            grant_ok;
    logic [NR-1:0] eg;
    logic [143:0]  exp_data;
    cur_req = cur_req | set_bits;
    if (cur_req == '0) cur_req = 1;
    i_req        = cur_req;
    i_req_data   = d;
    i_req_cmd    = cm;
    i_enc_output = eo;
    i_enc_done   = stuck || glitch;
    w       = rr_pick(cur_req, m_last);
    eg      = '0;
    eg[w]   = 1'b1;
    exp_r   = stuck ? 4 : 3 + ((k < TMO) ? k : TMO);
    exp_err = !stuck && (k > TMO);
    exp_data = exp_err ? 144'd0 : eo;
    r_obs    = -1;
    starts   = 0;
    grant_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (o_enc_start) starts++;
      if (o_grant !== eg) grant_ok = 1'b0;
      if (c == 1) begin
        chk("launch_data", o_enc_input_data, d[32*w +: 32]);
        chk("launch_cmd", o_enc_cmd, cm[4*w +: 4]);
        chk("launch_busy", o_busy, 1'b1);
      end
      if (o_resp_valid != '0) begin
        r_obs = c;
        chk("resp_valid", o_resp_valid, eg);
        chk("resp_data", o_resp_data, exp_data);
        chk("resp_error", o_resp_error, exp_err);
        if (!hold) cur_req[w] = 1'b0;
        i_req      = cur_req;
        i_enc_done = stuck;
        @(negedge clk);
        chk("idle_busy", o_busy, 1'b0);
        chk("idle_grant", o_grant, '0);
        chk("idle_start", o_enc_start, 1'b0);
        chk("idle_valid", o_resp_valid, '0);
        chk("idle_data_hold", o_resp_data, exp_data);
        break;
      end
      i_enc_done = stuck || (glitch && c == 2) || (c == 2 + k);
      if (c == 3 && late) cur_req[(w + 1) % NR] = 1'b1;
      if (c == 3 && drop) cur_req[w] = 1'b0;
      i_req      = cur_req;
      i_req_data = rnd64();
      i_req_cmd  = 8'($urandom);
    end
    chk("resp_latency", r_obs, exp_r);
    chk("grant_hold", grant_ok, 1'b1);
    chk("start_pulses", starts, 1);
    m_last = w;
  endtask

  initial begin
    reset        = 1'b1;
    i_req        = '0;
    i_req_data   = '0;
    i_req_cmd    = '0;
    i_enc_output = '0;
    i_enc_done   = 1'b1;
    cur_req      = '0;
    m_last       = NR - 1;
    repeat (3) @(negedge clk);
    chk("rst_grant", o_grant, '0);
    chk("rst_valid", o_resp_valid, '0);
    chk("rst_data", o_resp_data, '0);
    chk("rst_error", o_resp_error, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_enc_data", o_enc_input_data, '0);
    chk("rst_enc_cmd", o_enc_cmd, '0);
    chk("rst_start", o_enc_start, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("noreq_busy", o_busy, 1'b0);

    run_txn(2'b01, {32'h0, 32'h0000ABCD}, {4'h0, 4'h1}, {18{8'hA5}}, 3, 0, 0, 0, 0, 0);

    for (int t = 0; t < 4; t++)
      run_txn(2'b11, rnd64(), 8'($urandom), rnd144(), $urandom_range(1, 6), 0, 1, 0, 0, 1);
    cur_req = '0;

    run_txn(2'b01, rnd64(), 8'($urandom), rnd144(), 5, 0, 0, 1, 0, 0);
    run_txn(2'b00, rnd64(), 8'($urandom), rnd144(), 2, 0, 0, 0, 0, 0);

    run_txn(2'b01, rnd64(), 8'($urandom), rnd144(), 20, 0, 0, 0, 0, 0);
    run_txn(2'b10, rnd64(), 8'($urandom), rnd144(), 8, 0, 0, 0, 0, 0);
    run_txn(2'b01, rnd64(), 8'($urandom), rnd144(), 4, 0, 0, 0, 0, 0);

    run_txn(2'b10, rnd64(), 8'($urandom), rnd144(), 5, 1, 0, 0, 0, 0);

    run_txn(2'b01, rnd64(), 8'($urandom), rnd144(), 4, 0, 0, 0, 1, 1);

    cur_req    = 2'b11;
    i_req      = cur_req;
    i_enc_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_grant", o_grant, '0);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_start", o_enc_start, 1'b0);
    chk("midrst_valid", o_resp_valid, '0);
    chk("midrst_data", o_resp_data, '0);
    chk("midrst_enc_data", o_enc_input_data, '0);
    @(negedge clk);
    reset  = 1'b0;
    m_last = NR - 1;
    chk("postrst_valid", o_resp_valid, '0);
    run_txn(2'b11, rnd64(), 8'($urandom), rnd144(), 3, 0, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++)
      run_txn(2'($urandom), rnd64(), 8'($urandom), rnd144(), $urandom_range(1, 11),
              ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
